// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: state codes,
// supported opcodes and the ALU / PC select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Control word decode: maps the current state plus Mem_Ready / Zero to the
// datapath strobes and selects. Purely combinational.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    input  logic       rst,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    // Per-state control word; strobes are masked while reset is held so an
    // interrupted memory access or write-back never fires.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_en         = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase

        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end

        pc_en = pc_write | (pc_write_cond & zero & ~rst);
    end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
//
// state       | meaning
// ------------+-----------------------------------------------
// FETCH       | read instruction at PC, PC += 4 when memory ready
// DECODE      | register read, branch target into ALUOut
// MEM_ADDR    | effective address for LW/SW
// MEM_READ    | data read, waits for Mem_Ready
// MEM_WB      | load result into rt
// MEM_WRITE   | data write, waits for Mem_Ready
// EXECUTE     | R-type ALU operation
// R_WB        | R-type result into rd
// BRANCH      | compare, PC <= ALUOut when Zero
// JUMP        | PC <= jump target
// ADDI_EXEC   | A + sign-extended immediate
// ADDI_WB     | ADDI result into rt
module multi_cycle_control
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       Pc_Write,
    output logic       Pc_Write_Cond,
    output logic       Pc_En,
    output logic       IorD,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       Ir_Write,
    output logic       Mem_To_Reg,
    output logic       Reg_Dst,
    output logic       Reg_Write,
    output logic       Alu_Src_A,
    output logic [1:0] Alu_Src_B,
    output logic [1:0] Alu_OP,
    output logic [1:0] Pc_Source,
    output logic       Illegal_Op
);

    state_t state_q;
    state_t state_d;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; memory states hold until Mem_Ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = Mem_Ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ:  state_d = Mem_Ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = Mem_Ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // Unsupported opcode flag, only meaningful while decoding.
    always_comb begin
        Illegal_Op = (state_q == S_DECODE) && !op_supported(Opcode) && !rst;
    end

    mc_ctrl_decode u_decode (
        .state         (state_q),
        .mem_ready     (Mem_Ready),
        .zero          (Zero),
        .rst           (rst),
        .pc_write      (Pc_Write),
        .pc_write_cond (Pc_Write_Cond),
        .pc_en         (Pc_En),
        .iord          (IorD),
        .mem_read      (Mem_Read),
        .mem_write     (Mem_Write),
        .ir_write      (Ir_Write),
        .mem_to_reg    (Mem_To_Reg),
        .reg_dst       (Reg_Dst),
        .reg_write     (Reg_Write),
        .alu_src_a     (Alu_Src_A),
        .alu_src_b     (Alu_Src_B),
        .alu_op        (Alu_OP),
        .pc_source     (Pc_Source)
    );

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. A reference model expands
// each instruction into the cycle-by-cycle control words it should produce.
module tb_multi_cycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

    typedef struct {
        logic       r;
        logic       mr;
        logic       z;
        logic [5:0] op;
        ctrl_t      exp;
    } step_t;

    logic       clk;
    logic       rst;
    logic [5:0] Opcode;
    logic       Zero;
    logic       Mem_Ready;
    logic       Pc_Write, Pc_Write_Cond, Pc_En, IorD, Mem_Read, Mem_Write;
    logic       Ir_Write, Mem_To_Reg, Reg_Dst, Reg_Write, Alu_Src_A, Illegal_Op;
    logic [1:0] Alu_Src_B, Alu_OP, Pc_Source;

    int    n_checks;
    int    n_fail;
    step_t plan[$];

    multi_cycle_control dut (
        .clk           (clk),
        .rst           (rst),
        .Opcode        (Opcode),
        .Zero          (Zero),
        .Mem_Ready     (Mem_Ready),
        .Pc_Write      (Pc_Write),
        .Pc_Write_Cond (Pc_Write_Cond),
        .Pc_En         (Pc_En),
        .IorD          (IorD),
        .Mem_Read      (Mem_Read),
        .Mem_Write     (Mem_Write),
        .Ir_Write      (Ir_Write),
        .Mem_To_Reg    (Mem_To_Reg),
        .Reg_Dst       (Reg_Dst),
        .Reg_Write     (Reg_Write),
        .Alu_Src_A     (Alu_Src_A),
        .Alu_Src_B     (Alu_Src_B),
        .Alu_OP        (Alu_OP),
        .Pc_Source     (Pc_Source),
        .Illegal_Op    (Illegal_Op)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    task automatic push(input logic r, input logic mr, input logic z, input logic [5:0] op,
                        input ctrl_t w);
        step_t s;
        s.r = r; s.mr = mr; s.z = z; s.op = op; s.exp = w;
        plan.push_back(s);
    endtask

    // Instruction fetch: waits stall cycles, then the read completes.
    task automatic plan_fetch(input logic [5:0] op, input int waits);
        ctrl_t w;
        for (int i = 0; i <= waits; i++) begin
            w = '0;
            w.mem_read  = 1'b1;
            w.alu_src_b = 2'b01;
            if (i == waits) begin
                w.ir_write = 1'b1;
                w.pc_write = 1'b1;
                w.pc_en    = 1'b1;
            end
            push(1'b0, (i == waits), rbit(), op, w);
        end
    endtask

    // One stalled fetch cycle: proves the previous instruction ended in FETCH.
    task automatic plan_stall();
        ctrl_t w;
        w = '0;
        w.mem_read  = 1'b1;
        w.alu_src_b = 2'b01;
        push(1'b0, 1'b0, rbit(), 6'($urandom), w);
    endtask

    // Whole instruction; br_zero < 0 picks a random Zero for the branch cycle.
    task automatic plan_instr(input logic [5:0] op, input int fw, input int mw, input int br_zero);
        ctrl_t w;
        logic  z;
        plan_fetch(op, fw);
        w = '0;
        w.alu_src_b  = 2'b11;
        w.illegal_op = !legal(op);
        push(1'b0, rbit(), rbit(), op, w);
        case (op)
            6'b100011, 6'b101011: begin
                w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
                push(1'b0, rbit(), rbit(), op, w);
                for (int i = 0; i <= mw; i++) begin
                    w = '0; w.iord = 1'b1;
                    if (op == 6'b100011) w.mem_read = 1'b1;
                    else                 w.mem_write = 1'b1;
                    push(1'b0, (i == mw), rbit(), op, w);
                end
                if (op == 6'b100011) begin
                    w = '0; w.reg_write = 1'b1; w.mem_to_reg = 1'b1;
                    push(1'b0, rbit(), rbit(), op, w);
                end
            end
            6'b000000: begin
                w = '0; w.alu_src_a = 1'b1; w.alu_op = 2'b10;
                push(1'b0, rbit(), rbit(), op, w);
                w = '0; w.reg_write = 1'b1; w.reg_dst = 1'b1;
                push(1'b0, rbit(), rbit(), op, w);
            end
            6'b000100: begin
                z = (br_zero < 0) ? rbit() : (br_zero != 0);
                w = '0; w.alu_src_a = 1'b1; w.alu_op = 2'b01;
                w.pc_write_cond = 1'b1; w.pc_source = 2'b01; w.pc_en = z;
                push(1'b0, rbit(), z, op, w);
            end
            6'b000010: begin
                w = '0; w.pc_write = 1'b1; w.pc_en = 1'b1; w.pc_source = 2'b10;
                push(1'b0, rbit(), rbit(), op, w);
            end
            6'b001000: begin
                w = '0; w.alu_src_a = 1'b1; w.alu_src_b = 2'b10;
                push(1'b0, rbit(), rbit(), op, w);
                w = '0; w.reg_write = 1'b1;
                push(1'b0, rbit(), rbit(), op, w);
            end
            default: ;
        endcase
    endtask

    // Drive one cycle's inputs, sample outputs at the falling edge, then
    // advance to just after the next rising edge.
    task automatic cycle(input step_t s, output ctrl_t obs);
        rst       = s.r;
        Mem_Ready = s.mr;
        Zero      = s.z;
        Opcode    = s.op;
        @(negedge clk);
        obs.pc_write      = Pc_Write;
        obs.pc_write_cond = Pc_Write_Cond;
        obs.pc_en         = Pc_En;
        obs.iord          = IorD;
        obs.mem_read      = Mem_Read;
        obs.mem_write     = Mem_Write;
        obs.ir_write      = Ir_Write;
        obs.mem_to_reg    = Mem_To_Reg;
        obs.reg_dst       = Reg_Dst;
        obs.reg_write     = Reg_Write;
        obs.alu_src_a     = Alu_Src_A;
        obs.alu_src_b     = Alu_Src_B;
        obs.alu_op        = Alu_OP;
        obs.pc_source     = Pc_Source;
        obs.illegal_op    = Illegal_Op;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ctrl_t obs;
        ctrl_t w;
        step_t s;
        logic [6:0] strobes;
        rst = 1'b1; Mem_Ready = 1'b1; Zero = 1'b1; Opcode = 6'b000000;
        #2;
        strobes = {Pc_Write, Pc_En, Ir_Write, Mem_Read, Mem_Write, Reg_Write, Illegal_Op};
        n_checks++;
        if (strobes !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected %b", strobes, 7'b0);
        end
        w = '0;
        w.alu_src_b = 2'b01;
        for (int i = 0; i < 2; i++) begin
            s.r = 1'b1; s.mr = 1'b1; s.z = 1'b1; s.op = 6'b000000; s.exp = w;
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, s.exp);
            end
        end
        plan.delete();
        plan_stall();
        s = plan.pop_front();
        cycle(s, obs);
        n_checks++;
        if (obs !== s.exp) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, s.exp);
        end
    endtask

    task automatic test_rtype();
        ctrl_t obs;
        step_t s;
        int    k = 0;
        plan.delete();
        plan_instr(6'b000000, 0, 0, -1);
        plan_stall();
        while (plan.size() > 0) begin
            s = plan.pop_front();
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL rtype step %0d: got %h expected %h", k, obs, s.exp);
            end
            k++;
        end
    endtask

    task automatic test_lw_wait();
        ctrl_t obs;
        step_t s;
        int    k = 0;
        plan.delete();
        plan_instr(6'b100011, 0, 2, -1);
        plan_stall();
        while (plan.size() > 0) begin
            s = plan.pop_front();
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL lw_wait step %0d: got %h expected %h", k, obs, s.exp);
            end
            k++;
        end
    endtask

    task automatic test_beq();
        ctrl_t obs;
        step_t s;
        int    k = 0;
        plan.delete();
        plan_instr(6'b000100, 0, 0, 1);
        plan_instr(6'b000100, 1, 0, 0);
        plan_stall();
        while (plan.size() > 0) begin
            s = plan.pop_front();
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL beq step %0d: got %h expected %h", k, obs, s.exp);
            end
            k++;
        end
    endtask

    task automatic test_illegal();
        ctrl_t obs;
        step_t s;
        int    k = 0;
        plan.delete();
        plan_instr(6'b111111, 0, 0, -1);
        plan_stall();
        while (plan.size() > 0) begin
            s = plan.pop_front();
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL illegal step %0d: got %h expected %h", k, obs, s.exp);
            end
            k++;
        end
    endtask

    task automatic test_reset_mid_write();
        ctrl_t obs;
        step_t s;
        int    k = 0;
        plan.delete();
        plan_instr(6'b101011, 0, 0, -1);
        s = plan.pop_back();
        s.r  = 1'b1;
        s.mr = 1'b1;
        s.exp.mem_write = 1'b0;
        plan.push_back(s);
        plan_instr(6'b101011, 0, 0, -1);
        plan_instr(6'b000010, 0, 0, -1);
        plan_stall();
        while (plan.size() > 0) begin
            s = plan.pop_front();
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL reset_mid_write step %0d: got %h expected %h", k, obs, s.exp);
            end
            k++;
        end
    endtask

    task automatic test_random();
        ctrl_t      obs;
        step_t      s;
        int         k = 0;
        logic [5:0] ops [7];
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
        plan.delete();
        for (int n = 0; n < 30; n++) begin
            ops[6] = 6'($urandom);
            plan_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 2),
                       $urandom_range(0, 2), -1);
        end
        plan_stall();
        while (plan.size() > 0) begin
            s = plan.pop_front();
            cycle(s, obs);
            n_checks++;
            if (obs !== s.exp) begin
                n_fail++;
                $display("FAIL random step %0d op %b: got %h expected %h", k, s.op, obs, s.exp);
            end
            k++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
